// File: rtl/bram_rd_arbiter_pkg.sv
// Shared constants and types for the two-requester BRAM read arbiter.
package bram_rd_arbiter_pkg;

  localparam int unsigned DEFAULT_DEPTH  = 9;
  localparam int unsigned DEFAULT_ADDR_W = 4;
  localparam int unsigned DEFAULT_DATA_W = 8;

  // Requester ids as carried in the stage-1 pipeline register
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Stage-1 tracking of the read granted in the previous cycle
  typedef struct packed {
    logic valid;
    logic id;
    logic err;
  } s1_t;

endpackage

// File: rtl/bram_rd_arbiter_rr_arb2.sv
// Two-way round-robin grant logic. The requester not granted most recently wins a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_gnt_q, last_gnt_d;

  // Combinational grant; suppressed entirely while reset is asserted
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_gnt_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Remember who was granted last; hold when nobody is granted
  always_comb begin
    last_gnt_d = last_gnt_q;
    if (gnt[1]) begin
      last_gnt_d = 1'b1;
    end else if (gnt[0]) begin
      last_gnt_d = 1'b0;
    end
  end

  // Reset to 1 so requester 0 wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_q <= 1'b1;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule

// File: rtl/bram_rd_arbiter.sv
// Shares one synchronous BRAM read port between two requesters. Grants are combinational,
// the RAM returns data one cycle later, and responses are registered to the owner at T+2.
module bram_rd_arbiter
  import bram_rd_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH  = DEFAULT_DEPTH,
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp0_err,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              rsp1_err,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_data
);

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly
  localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(DEPTH);

  logic [1:0]        gnt;
  logic              granted;
  logic              gnt_id;
  logic [ADDR_W-1:0] gnt_addr;
  logic              addr_ok;
  s1_t               s1_q, s1_d;

  rr_arb2 u_rr_arb2 (
    .clk (clk),
    .rst (rst),
    .req ({req1, req0}),
    .gnt (gnt)
  );

  assign gnt0 = gnt[0];
  assign gnt1 = gnt[1];

  // Select the granted address, range-check it, and drive the RAM port only when legal
  always_comb begin
    granted     = |gnt;
    gnt_id      = gnt[1] ? REQ1 : REQ0;
    gnt_addr    = gnt[1] ? addr1 : addr0;
    addr_ok     = {1'b0, gnt_addr} < DepthLim;
    mem_rd_en   = granted && addr_ok;
    mem_rd_addr = mem_rd_en ? gnt_addr : '0;
    s1_d.valid  = granted;
    s1_d.id     = gnt_id;
    s1_d.err    = granted && !addr_ok;
  end

  // Stage 1: track the read in flight while the RAM produces its data
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
    end else begin
      s1_q <= s1_d;
    end
  end

  // Stage 2: route the returned word to its owner; data/err hold while valid is low
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_data  <= '0;
      rsp1_err   <= 1'b0;
    end else begin
      rsp0_valid <= s1_q.valid && (s1_q.id == REQ0);
      rsp1_valid <= s1_q.valid && (s1_q.id == REQ1);
      if (s1_q.valid && (s1_q.id == REQ0)) begin
        rsp0_data <= s1_q.err ? '0 : mem_data;
        rsp0_err  <= s1_q.err;
      end
      if (s1_q.valid && (s1_q.id == REQ1)) begin
        rsp1_data <= s1_q.err ? '0 : mem_data;
        rsp1_err  <= s1_q.err;
      end
    end
  end

endmodule

// File: tb/tb_bram_rd_arbiter.sv
// Scoreboard bench for bram_rd_arbiter: a driver predicts grants and pushes expected
// responses; an independent monitor pops and compares whenever a response strobe appears.
module tb_bram_rd_arbiter;

  localparam int Depth = 9;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [3:0] addr0 = '0, addr1 = '0;
  logic       gnt0, gnt1;
  logic       rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [7:0] rsp0_data, rsp1_data;
  logic       mem_rd_en;
  logic [3:0] mem_rd_addr;
  logic [7:0] mem_data;

  bram_rd_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req0        (req0),
    .addr0       (addr0),
    .gnt0        (gnt0),
    .rsp0_valid  (rsp0_valid),
    .rsp0_data   (rsp0_data),
    .rsp0_err    (rsp0_err),
    .req1        (req1),
    .addr1       (addr1),
    .gnt1        (gnt1),
    .rsp1_valid  (rsp1_valid),
    .rsp1_data   (rsp1_data),
    .rsp1_err    (rsp1_err),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_data    (mem_data)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: word[i] = i+1 in range, a marker value beyond it
  logic [7:0] ram [16];
  initial begin
    for (int i = 0; i < 16; i++) ram[i] = (i < Depth) ? 8'(i + 1) : 8'hEE;
  end
  always @(posedge clk) if (mem_rd_en) mem_data <= ram[mem_rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit       id;
    bit [7:0] data;
    bit       err;
    int       due;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference arbitration state: who was granted most recently
  bit model_last = 1'b1;

  // Drive one cycle of inputs, then check the combinational outputs against the model
  task automatic step(input bit r0, input int a0, input bit r1, input int a1, input bit rs);
    bit   g0, g1;
    int   ga;
    exp_t e;
    @(posedge clk);
    #1;
    req0 = r0; addr0 = 4'(a0); req1 = r1; addr1 = 4'(a1); rst = rs;
    #1;
    g0 = 0; g1 = 0;
    if (!rs) begin
      if (r0 && r1) begin
        if (model_last) g0 = 1; else g1 = 1;
      end else begin
        g0 = r0; g1 = r1;
      end
    end
    chk("gnt0", int'(gnt0), int'(g0));
    chk("gnt1", int'(gnt1), int'(g1));
    ga = g1 ? a1 : a0;
    if (g0 || g1) begin
      chk("mem_rd_en", int'(mem_rd_en), (ga < Depth) ? 1 : 0);
      chk("mem_rd_addr", int'(mem_rd_addr), (ga < Depth) ? ga : 0);
      e.id   = g1;
      e.err  = (ga >= Depth);
      e.data = e.err ? 8'd0 : 8'(ga + 1);
      e.due  = cyc + 2;
      exp_q.push_back(e);
      model_last = g1;
    end else begin
      chk("mem_rd_en_idle", int'(mem_rd_en), 0);
      chk("mem_rd_addr_idle", int'(mem_rd_addr), 0);
    end
    if (rs) model_last = 1'b1;
  endtask

  // Monitor: compare responses, check holding outputs, and honour reset
  bit       armed = 0;
  bit [7:0] last_d0 = 0, last_d1 = 0;
  bit       last_e0 = 0, last_e1 = 0;
  always @(negedge clk) begin
    if (armed) begin
      if (rsp0_valid === 1'b1 && rsp1_valid === 1'b1) begin
        chk("both_valid", 1, 0);
      end else if (rsp0_valid === 1'b1 || rsp1_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_id", int'(rsp1_valid), int'(e.id));
          chk("rsp_cycle", cyc, e.due);
          chk("rsp_data", int'(rsp1_valid ? rsp1_data : rsp0_data), int'(e.data));
          chk("rsp_err", int'(rsp1_valid ? rsp1_err : rsp0_err), int'(e.err));
        end
        if (rsp0_valid === 1'b1) begin
          last_d0 = rsp0_data; last_e0 = rsp0_err;
          chk("rsp1_hold_data", int'(rsp1_data), int'(last_d1));
        end else begin
          last_d1 = rsp1_data; last_e1 = rsp1_err;
          chk("rsp0_hold_data", int'(rsp0_data), int'(last_d0));
        end
      end else begin
        chk("rsp_valid_low", int'(rsp0_valid) + int'(rsp1_valid), 0);
        if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
          chk("rsp_missing", 0, 1);
          void'(exp_q.pop_front());
        end
        chk("hold0", {23'd0, rsp0_err, rsp0_data}, {23'd0, last_e0, last_d0});
        chk("hold1", {23'd0, rsp1_err, rsp1_data}, {23'd0, last_e1, last_d1});
      end
    end
    if (rst === 1'b1) begin
      armed = 1;
      last_d0 = 0; last_d1 = 0; last_e0 = 0; last_e1 = 0;
      while (exp_q.size() > 0 && exp_q[$].due > cyc) void'(exp_q.pop_back());
    end
  end

  initial begin
    // Reset held with req0 pending: no grant, then granted on the first free cycle
    for (int i = 0; i < 3; i++) step(1, 3, 0, 0, 1);
    step(1, 3, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    // Fresh reset, then a sustained tie alternates 0,1,0,1
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 2, 1, 5, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    // Out-of-range then top legal address on requester 1
    step(0, 0, 1, 9, 0);
    step(0, 0, 1, 8, 0);
    step(0, 0, 1, 15, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    // Read killed by reset in the following cycle; tie afterwards goes to requester 0
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    // Back-to-back sweep over every legal address
    for (int a = 0; a < Depth; a++) step(1, a, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), $urandom_range(0, 15),
           1'($urandom_range(0, 1)), $urandom_range(0, 15),
           $urandom_range(0, 39) == 0);
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bram_rd_arbiter.md
Name: bram_rd_arbiter

Overview:
- Two-requester, round-robin arbiter that shares the single read port of a small synchronous block RAM (default 9 x 8-bit, 1-cycle read latency, rd_en/rd_addr in, data_out registered).
- Grants at most one request per cycle and drives the RAM read port.
- Tracks the in-flight read, then routes the returned byte back to the owning requester with a fixed latency.
- Rejects out-of-range addresses without touching the RAM.

Parameters:
- DEPTH, 9, number of valid RAM words; addresses 0..DEPTH-1 are legal.
- ADDR_W, 4, address width; must satisfy 2**ADDR_W >= DEPTH.
- DATA_W, 8, RAM word width.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 read request; held until granted.
- addr0  in  ADDR_W  requester 0 address; must be stable while req0 is high.
- gnt0  out  1  combinational grant to requester 0; request is consumed this cycle.
- rsp0_valid  out  1  one-cycle response strobe to requester 0.
- rsp0_data  out  DATA_W  response data to requester 0.
- rsp0_err  out  1  address was out of range; data is 0.
- req1, addr1, gnt1, rsp1_valid, rsp1_data, rsp1_err: same as the requester 0 ports, for requester 1.
- mem_rd_en  out  1  to RAM rd_en.
- mem_rd_addr  out  ADDR_W  to RAM rd_addr.
- mem_data  in  DATA_W  from RAM data_out.

Behaviour:
- Arbitration (combinational, same cycle):
  - Only one requester high: it is granted.
  - Both high: the requester not granted most recently wins.
  - last_gnt register updates on every grant; reset value 1, so requester 0 wins the first tie.
- Grant of a legal address (addr < DEPTH) in cycle T:
  - mem_rd_en=1 and mem_rd_addr=addrN in T.
  - Stage-1 register captures s1_valid=1, s1_id=N, s1_err=0.
- Grant of an illegal address (addr >= DEPTH):
  - mem_rd_en stays 0 and mem_rd_addr is driven 0.
  - Stage-1 captures s1_valid=1, s1_id=N, s1_err=1.
  - The RAM is never read with an out-of-range address.
- When no grant occurs, mem_rd_en=0, mem_rd_addr=0 and s1_valid<=0.
- Response (edge ending T+1):
  - Output registers load rspN_valid=1 for N=s1_id.
  - rspN_data = s1_err ? 0 : mem_data.
  - rspN_err = s1_err.
  - The other requester's valid is 0.
- Latency: grant in T -> rsp*_valid high in T+2, for exactly 1 cycle.
  - Data/err outputs hold their last value when valid is 0.
- Throughput:
  - One grant per cycle, back-to-back; the pipeline never stalls.
  - Requesters always accept responses; there is no response backpressure.
- Fairness: with both requesters continuously requesting, grants alternate 0,1,0,1...
- The arbiter never relies on any RAM-side valid (the RAM has no reset). Response validity derives only from s1_valid.
- Reset, effective at the next edge:
  - last_gnt=1, s1_valid=0.
  - All rsp*_valid=0, rsp*_data=0, rsp*_err=0.
  - gnt*/mem_rd_en are 0 while rst is high, even if requests are present.
  - A read granted in the cycle before reset produces no response.
- Simultaneous events:
  - A grant in T and a response for T-2 coexist and are independent.
  - A requester may re-request in the cycle its previous response arrives.
- Width rules:
  - Address compare is unsigned, at ADDR_W bits.
  - s1_id is 1 bit.
  - mem_data is passed through unmodified.

Decomposition:
- Shared package constants: DEPTH, ADDR_W, DATA_W default values, and the requester-id localparams REQ0=0, REQ1=1.
- One natural sub-module, rr_arb2: 2-way round-robin grant logic with the last_gnt register (inputs req[1:0], rst; outputs gnt[1:0]).
- Pipeline and response routing stay in bram_rd_arbiter.

Test Plan:
- RAM initialised to word[i]=i+1. Reset, then req0=1 with addr0=3 for one cycle -> gnt0=1 and mem_rd_addr=3 in T; rsp0_valid=1, rsp0_data=4, rsp0_err=0 at T+2; rsp1_valid stays 0.
- req0 and req1 high together (addr0=2, addr1=5) for 4 cycles after reset -> grants 0,1,0,1; rsp0 returns 3,3 and rsp1 returns 6,6, each 2 cycles after its grant.
- req1=1 with addr1=9 -> gnt1=1, mem_rd_en=0; at T+2 rsp1_valid=1, rsp1_err=1, rsp1_data=0. Then addr1=8 -> rsp1_data=9, rsp1_err=0.
- Grant req0 addr=1 in T, assert rst in T+1 -> no rsp0_valid at T+2; all outputs 0. After reset deassert, a tie grants requester 0 first.
- Back-to-back req0 addresses 0..8 on consecutive cycles -> 9 consecutive rsp0_valid cycles carrying 1..9, with no gaps.
- req0 held with rst high for 3 cycles -> gnt0=0 and mem_rd_en=0 throughout. Deassert rst -> gnt0=1 on the first cycle after.
